// File: rtl/mipi_raw_unpacker.sv
// mipi_raw_unpacker: CSI-2 payload byte stream to 4-pixel beats (RAW8/RAW10/RAW12)
// with line framing and residual-byte error reporting.
module mipi_raw_unpacker #(
    parameter int IN_BYTES  = 4,
    parameter int PIX_W     = 12,
    parameter int ACC_BYTES = IN_BYTES + 6
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic [1:0]                   mode_i,
    input  logic [8*IN_BYTES-1:0]        in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         in_sol_i,
    input  logic                         in_eol_i,
    input  logic [$clog2(IN_BYTES+1)-1:0] in_bytes_i,
    output logic [4*PIX_W-1:0]           out_pix_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_sol_o,
    output logic                         out_eol_o,
    output logic                         err_residual_o,
    output logic [7:0]                   residual_cnt_o
);
    localparam int CW = $clog2(ACC_BYTES + 1);

    logic [7:0]  acc [ACC_BYTES];
    logic [7:0]  nxt [ACC_BYTES];
    logic [CW:0] cnt, need, rem, base, add, cnt_nxt;
    logic [1:0]  mode;
    logic        sol_pend, eol_pend, out_fire, in_fire, sol_acc, tail;
    logic [7:0]  res_cnt;
    logic [PIX_W-1:0] p0, p1, p2, p3;

    always_comb begin
        need        = (CW+1)'(mode == 2'd1 ? 5 : mode == 2'd2 ? 6 : 4);
        out_valid_o = ~wb_rst_i & (cnt >= need);
        out_fire    = out_valid_o & out_ready_i;
        rem         = out_fire ? cnt - need : cnt;
        in_ready_o  = ~wb_rst_i & ~eol_pend & (rem + (CW+1)'(IN_BYTES) <= (CW+1)'(ACC_BYTES));
        in_fire     = in_valid_i & in_ready_o;
        sol_acc     = in_fire & in_sol_i;
        // end of a terminated line: last beat leaves, or too few bytes remain for a beat
        tail        = eol_pend & (out_fire ? rem < need : ~out_valid_o);
        err_residual_o = ~wb_rst_i & (sol_acc | tail) & (rem != '0);
        out_sol_o   = out_valid_o & sol_pend;
        out_eol_o   = out_valid_o & eol_pend & (cnt - need < need);
        base        = in_sol_i ? '0 : rem;
        add         = in_eol_i ? (CW+1)'(in_bytes_i) : (CW+1)'(IN_BYTES);
        cnt_nxt     = tail ? '0 : in_fire ? base + add : rem;
        for (int i = 0; i < ACC_BYTES; i++) begin
            nxt[i] = acc[i];
            for (int s = 4; s <= 6; s++)
                if (out_fire && need == (CW+1)'(s)) nxt[i] = (i + s < ACC_BYTES) ? acc[(i+s)%ACC_BYTES] : 8'h00;
            for (int j = 0; j < IN_BYTES; j++)
                if (in_fire && (CW+1)'(j) < add && (CW+1)'(i) == base + (CW+1)'(j)) nxt[i] = in_data_i[8*j +: 8];
        end
        p0 = mode == 2'd1 ? {acc[0], acc[4][1:0], 2'b00} : mode == 2'd2 ? {acc[0], acc[2][3:0]} : {acc[0], 4'h0};
        p1 = mode == 2'd1 ? {acc[1], acc[4][3:2], 2'b00} : mode == 2'd2 ? {acc[1], acc[2][7:4]} : {acc[1], 4'h0};
        p2 = mode == 2'd1 ? {acc[2], acc[4][5:4], 2'b00} : mode == 2'd2 ? {acc[3], acc[5][3:0]} : {acc[2], 4'h0};
        p3 = mode == 2'd1 ? {acc[3], acc[4][7:6], 2'b00} : mode == 2'd2 ? {acc[4], acc[5][7:4]} : {acc[3], 4'h0};
        out_pix_o      = out_valid_o ? {p3, p2, p1, p0} : '0;
        residual_cnt_o = wb_rst_i ? 8'h00 : res_cnt;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt      <= '0;
            mode     <= 2'd0;
            sol_pend <= 1'b0;
            eol_pend <= 1'b0;
            res_cnt  <= 8'h00;
            acc      <= '{default: 8'h00};
        end else begin
            cnt      <= cnt_nxt;
            acc      <= nxt;
            if (sol_acc) mode <= mode_i;
            sol_pend <= sol_acc | (sol_pend & ~out_fire & ~tail);
            eol_pend <= (in_fire & in_eol_i) | (eol_pend & (cnt_nxt != '0));
            if (err_residual_o && res_cnt != 8'hFF) res_cnt <= res_cnt + 8'h01;
        end
    end
endmodule

// File: tb/tb_mipi_raw_unpacker.sv
// tb_mipi_raw_unpacker: directed self-checking bench for mipi_raw_unpacker.
module tb_mipi_raw_unpacker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_ready, in_sol = 1'b0, in_eol = 1'b0;
    logic [2:0]  in_bytes = 3'd4;
    logic [47:0] pix;
    logic        out_valid, out_ready = 1'b1, out_sol, out_eol, err;
    logic [7:0]  res;
    logic        tog = 1'b0;
    int          total = 0, bad = 0, errs = 0;
    logic [47:0] q_pix [$];
    logic        q_sol [$];
    logic        q_eol [$];

    always #5 clk = ~clk;

    mipi_raw_unpacker dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .mode_i(mode), .in_data_i(in_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sol_i(in_sol), .in_eol_i(in_eol),
        .in_bytes_i(in_bytes), .out_pix_o(pix), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sol_o(out_sol), .out_eol_o(out_eol), .err_residual_o(err), .residual_cnt_o(res)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [2:0] n, input logic [1:0] m);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_data = d; in_sol = s; in_eol = e; in_bytes = n; mode = m; in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
    endtask

    task automatic drain();
        repeat (24) @(negedge clk);
    endtask

    task automatic clr();
        q_pix.delete(); q_sol.delete(); q_eol.delete(); errs = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = tog ? ~out_ready : 1'b1;
        end
    end

    initial begin
        logic ps, s0, e0;
        logic [47:0] pp;
        ps = 1'b0; s0 = 1'b0; e0 = 1'b0; pp = '0;
        forever begin
            @(negedge clk);
            if (rst) ps = 1'b0;
            else begin
                if (ps) begin
                    chk("stall_pix", pix, pp);
                    chk("stall_flags", {out_sol, out_eol}, {s0, e0});
                end
                if (out_valid && out_ready) begin
                    q_pix.push_back(pix); q_sol.push_back(out_sol); q_eol.push_back(out_eol);
                end
                if (err) errs++;
                ps = out_valid & ~out_ready; pp = pix; s0 = out_sol; e0 = out_eol;
            end
        end
    end

    initial begin
        logic [47:0] ex;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_pix", pix, 0);
        chk("rst_res", res, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        clr();

        // 1: RAW10 single group
        send(32'hDDCCBBAA, 1, 0, 4, 2'd1);
        send(32'h0000001B, 0, 1, 1, 2'd1);
        drain();
        chk("t1_beats", q_pix.size(), 1);
        if (q_pix.size() > 0) begin
            chk("t1_pix", q_pix[0], {12'hDD0, 12'hCC4, 12'hBB8, 12'hAAC});
            chk("t1_flags", {q_sol[0], q_eol[0]}, 2'b11);
        end
        chk("t1_err", errs, 0);
        clr();

        // 2: RAW12 single group
        send(32'h78563412, 1, 0, 4, 2'd2);
        send(32'h0000BC9A, 0, 1, 2, 2'd2);
        drain();
        chk("t2_beats", q_pix.size(), 1);
        if (q_pix.size() > 0) chk("t2_pix", q_pix[0], {12'h9AB, 12'h78C, 12'h345, 12'h126});
        chk("t2_err", errs, 0);
        clr();

        // 3: RAW8 16 beats with output back-pressure
        tog = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] d;
            for (int j = 0; j < 4; j++) d[8*j +: 8] = 8'(4*k + j + 1);
            send(d, k == 0, k == 15, 4, 2'd0);
        end
        drain();
        tog = 1'b0;
        chk("t3_beats", q_pix.size(), 16);
        for (int i = 0; i < 16 && i < q_pix.size(); i++) begin
            for (int j = 0; j < 4; j++) ex[12*j +: 12] = {8'(4*i + j + 1), 4'h0};
            chk("t3_pix", q_pix[i], ex);
            chk("t3_flags", {q_sol[i], q_eol[i]}, {i == 0, i == 15});
        end
        chk("t3_err", errs, 0);
        clr();

        // 4: RAW10 7-byte line leaves 2 residual bytes
        send(32'h44332211, 1, 0, 4, 2'd1);
        send(32'h00776655, 0, 1, 3, 2'd1);
        drain();
        chk("t4_beats", q_pix.size(), 1);
        if (q_pix.size() > 0) begin
            chk("t4_pix", q_pix[0], {12'h444, 12'h334, 12'h224, 12'h114});
            chk("t4_eol", q_eol[0], 1);
        end
        chk("t4_err", errs, 1);
        chk("t4_res", res, 1);
        clr();

        // 5: new sol with 3 bytes buffered, switch to RAW12
        send(32'h44332211, 1, 0, 4, 2'd1);
        send(32'h88776655, 0, 0, 4, 2'd1);
        send(32'h67452301, 1, 0, 4, 2'd2);
        send(32'h0000AB89, 0, 1, 2, 2'd2);
        drain();
        chk("t5_beats", q_pix.size(), 2);
        if (q_pix.size() > 1) begin
            chk("t5_pix_a", q_pix[0][11:0], 12'h114);
            chk("t5_flags_a", {q_sol[0], q_eol[0]}, 2'b10);
            chk("t5_pix_b", q_pix[1], {12'h89A, 12'h67B, 12'h234, 12'h015});
            chk("t5_flags_b", {q_sol[1], q_eol[1]}, 2'b11);
        end
        chk("t5_err", errs, 1);
        chk("t5_res", res, 2);
        clr();

        // 7: short RAW12 line never forms a group
        send(32'h00332211, 1, 1, 3, 2'd2);
        drain();
        chk("t7_beats", q_pix.size(), 0);
        chk("t7_err", errs, 1);
        chk("t7_res", res, 3);
        clr();

        // 6: reset mid-line with 4 bytes buffered
        send(32'h44332211, 1, 0, 4, 2'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_pix", pix, 0);
        chk("t6_flags", {out_sol, out_eol, err}, 0);
        chk("t6_res", res, 0);
        chk("t6_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        clr();
        send(32'h04030201, 1, 1, 4, 2'd0);
        drain();
        chk("t6_beats", q_pix.size(), 1);
        if (q_pix.size() > 0) begin
            chk("t6_line_pix", q_pix[0], {12'h040, 12'h030, 12'h020, 12'h010});
            chk("t6_line_flags", {q_sol[0], q_eol[0]}, 2'b11);
        end
        chk("t6_err", errs, 0);
        chk("t6_res_after", res, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end
endmodule

// File: doc/mipi_raw_unpacker.md
Name: mipi_raw_unpacker

Overview:
- Parametrised successor to the fixed 32-bit RAW10 unpacker in the CSI receive path.
- Takes the byte stream of CSI-2 long-packet payload, IN_BYTES bytes per beat. Emits 4 pixels per beat.
- Runtime-selectable RAW8/RAW10/RAW12 unpacking, valid/ready on both sides, line framing, and residual-byte error reporting.
- Sits between the D-PHY byte aligner/packet decoder and the ISP pixel pipeline.

Parameters:
IN_BYTES, 4, payload bytes per input beat; legal values 4 or 8.
PIX_W, 12, output pixel width; legal value 12 only.
ACC_BYTES, IN_BYTES+6, byte accumulator depth (derived; do not override).

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
mode_i  in  2  0=RAW8, 1=RAW10, 2=RAW12, 3=reserved (treated as RAW8); sampled only on an accepted in_sol_i beat
in_data_i  in  8*IN_BYTES  payload; byte0 = bits[7:0] = earliest byte
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
in_sol_i  in  1  first beat of line
in_eol_i  in  1  last beat of line
in_bytes_i  in  $clog2(IN_BYTES+1)  valid bytes in an eol beat (1..IN_BYTES); ignored otherwise (full beat)
out_pix_o  out  4*PIX_W  pixel0 in [PIX_W-1:0], pixel3 in top
out_valid_o  out  1  output beat valid
out_ready_i  in  1  output beat consumed when out_valid_o & out_ready_i
out_sol_o  out  1  first output beat of line
out_eol_o  out  1  last output beat of line
err_residual_o  out  1  one-cycle pulse: bytes discarded at line end/flush
residual_cnt_o  out  8  saturating count of err_residual_o pulses

Behaviour:
- Reset (sync, wb_rst_i=1): accumulator count=0, mode reg=RAW8, all flags cleared.
  - While reset is asserted: out_valid_o=0, out_pix_o=0, out_sol_o=0, out_eol_o=0, err_residual_o=0, residual_cnt_o=0, in_ready_o=0.
  - in_ready_o may rise the cycle after reset deasserts.
  - Reset mid-line discards everything; no error pulse.
- Group size NEED: RAW8=4, RAW10=5, RAW12=6 bytes per 4 pixels.
- Unpack rules, with B0 the oldest byte; outputs are MSB-aligned to 12 bits:
  - RAW8: Pn = Bn<<4.
  - RAW10: Pn = {Bn, B4[2n+1:2n]}<<2.
  - RAW12: P0={B0,B2[3:0]}, P1={B1,B2[7:4]}, P2={B3,B5[3:0]}, P3={B4,B5[7:4]}.
- Accumulator holds bytes in arrival order.
  - out_valid_o = (count >= NEED). The output register is the accumulator head (combinational unpack of registered bytes).
  - On an output handshake: shift out NEED bytes.
- in_ready_o = (count - (out fire ? NEED : 0) + IN_BYTES <= ACC_BYTES) & ~eol_pending & ~reset. Same-cycle input accept and output fire are legal; appended bytes land after the shifted remainder.
- Output stall (out_valid_o & ~out_ready_i): out_pix_o, out_sol_o and out_eol_o hold stable.
- sol beat accepted:
  - If the accumulator holds bytes (count>0) from a previous line with no eol seen, those bytes are flushed and err_residual_o pulses.
  - The mode register is loaded from mode_i.
  - The new beat's bytes start at position 0.
  - sol_pending is set; the next emitted beat carries out_sol_o=1.
- eol beat accepted: only in_bytes_i bytes are appended, and eol_pending is set (blocks input).
  - The emitted beat that leaves count < NEED carries out_eol_o=1.
  - Any remaining count>0 is then discarded with an err_residual_o pulse in the same cycle as that handshake.
  - If count < NEED immediately after the eol append, the bytes are discarded next cycle with err_residual_o, and no beat carries out_eol_o.
  - eol_pending clears once count=0.
- sol and eol on the same beat: single-beat line; both rules apply, sol flush first.
- Beats without a prior sol in the line are unpacked in the current mode. No error.
- residual_cnt_o increments per err_residual_o pulse and saturates at 255.
- Latency: the first output beat is valid 1 cycle after the accepted input beat that brings count >= NEED.
- Throughput: no bubbles while count >= NEED and out_ready_i=1.

Test Plan:
1. RAW10, IN_BYTES=4, sol beat 0xDDCCBBAA then eol beat 0x0000001B with in_bytes_i=1 -> one beat with P0=0xAAC, P1=0xBB8, P2=0xCC4, P3=0xDD0, out_sol_o=1 and out_eol_o=1; no err.
2. RAW12: bytes 12 34 56 78 9A BC (sol/eol, in_bytes_i=2 on the 2nd beat) -> P0=0x126, P1=0x345, P2=0x78C, P3=0x9AB.
3. RAW8, 16-beat line with out_ready_i toggling 1/0 each cycle -> 16 output beats; pixels equal bytes<<4 in order; out_pix_o stable during stalls; out_eol_o only on the 16th beat.
4. RAW10 line of 7 bytes (eol, in_bytes_i=3) -> 1 output beat with out_eol_o=1; err_residual_o pulses once; residual_cnt_o=1.
5. sol at mid-line with 3 bytes buffered, mode_i switched to RAW12 -> err_residual_o pulse; the next line unpacks as RAW12 with out_sol_o on its first beat.
6. Assert wb_rst_i mid-line with count=4 -> all outputs 0 next cycle; residual_cnt_o=0; the following RAW8 line unpacks cleanly.
